oled_pixel_tx: RTL and testbench

- Scan-side driver for the 96x64 RGB565 OLED.
- Sweeps pixel coordinates (x, y) out to a combinational pixel-colour source, such as a screen renderer.
- Registers the returned 16-bit colour and serialises it MSB-first over a 4-wire SPI link (cs_n, sclk, mosi, dc).
- Sits between the screen/renderer muxes and the OLED pins. Panel init/command sequencing is handled by a separate block; this block sends pixel data only.

---
 rtl/oled_pkg.sv | 23 ++
 rtl/oled_pixel_tx_if.sv | 29 ++
 rtl/spi_shift16.sv | 87 ++++++++
 rtl/oled_pixel_tx.sv | 124 ++++++++++++
 tb/tb_oled_pixel_tx.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/oled_pkg.sv
// Shared definitions for the OLED pixel transmitter: screen geometry,
// colour width, coordinate widths, scan FSM states and colour constants.
package oled_pkg;

    localparam int SCREEN_W   = 96;
    localparam int SCREEN_H   = 64;
    localparam int PIXEL_BITS = 16;

    // Coordinate port widths cover the 96x64 panel.
    localparam int X_BITS = 7;
    localparam int Y_BITS = 6;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        SHIFT,
        DONE
    } state_e;

    localparam logic [PIXEL_BITS-1:0] COL_BLACK = 16'h0000;
    localparam logic [PIXEL_BITS-1:0] COL_WHITE = 16'hFFFF;

endpackage

// File: rtl/oled_pixel_tx_if.sv
// Pixel transmitter bus: the frame request and colour come from the
// renderer side, the pixel coordinates and status flow back to it, and the
// SPI pins go out to the panel. The master side is the renderer/pin
// environment. The slave side is the transmitter.
interface oled_pixel_tx_if;
    import oled_pkg::*;

    logic                  frame_req;
    logic [PIXEL_BITS-1:0] pixel_data;
    logic [X_BITS-1:0]     x;
    logic [Y_BITS-1:0]     y;
    logic                  busy;
    logic                  frame_done;
    logic                  cs_n;
    logic                  sclk;
    logic                  mosi;
    logic                  dc;

    modport master (
        output frame_req, pixel_data,
        input  x, y, busy, frame_done, cs_n, sclk, mosi, dc
    );

    modport slave (
        input  frame_req, pixel_data,
        output x, y, busy, frame_done, cs_n, sclk, mosi, dc
    );

endinterface

// File: rtl/spi_shift16.sv
// 16-bit MSB-first SPI serialiser. A load pulse captures a word. Each bit
// then spends CLK_DIV cycles with sclk low followed by CLK_DIV cycles with
// sclk high, and the word shifts at the end of every high phase.
// bit_done_last flags the final cycle of bit 0's high phase.
module spi_shift16
    import oled_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [PIXEL_BITS-1:0] data,
    output logic                  bit_done_last,
    output logic                  sclk,
    output logic                  mosi
);

    localparam int               DIV_W    = $clog2(CLK_DIV) + 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [3:0]       BIT_LAST = 4'(PIXEL_BITS - 1);

    logic [DIV_W-1:0]      div_q, div_d;
    logic [3:0]            bit_cnt_q, bit_cnt_d;
    logic [PIXEL_BITS-1:0] shreg_q, shreg_d;
    logic                  sclk_q, sclk_d;
    logic                  active_q, active_d;
    logic                  phase_end;

    // Next-state logic: load a word, count out each sclk phase, shift after the high phase.
    always_comb begin
        // NOTE: every _d takes its hold value first, so no path leaves one unassigned and no latch is inferred.
        div_d     = div_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        sclk_d    = sclk_q;
        active_d  = active_q;

        phase_end     = active_q && (div_q == DIV_LAST);
        bit_done_last = phase_end && sclk_q && (bit_cnt_q == BIT_LAST);

        if (load) begin
            shreg_d   = data;
            sclk_d    = 1'b0;
            div_d     = '0;
            bit_cnt_d = '0;
            active_d  = 1'b1;
        end else if (phase_end) begin
            div_d = '0;
            if (!sclk_q) begin
                sclk_d = 1'b1;
            end else if (bit_cnt_q == BIT_LAST) begin
                // Word finished: park with sclk high and mosi on bit 0.
                active_d = 1'b0;
            end else begin
                shreg_d   = {shreg_q[PIXEL_BITS-2:0], 1'b0};
                bit_cnt_d = bit_cnt_q + 4'd1;
                sclk_d    = 1'b0;
            end
        end else if (active_q) begin
            div_d = div_q + DIV_W'(1);
        end
    end

    // Serialiser state registers; reset aborts any word in flight.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            div_q     <= '0;
            bit_cnt_q <= '0;
            shreg_q   <= COL_BLACK;
            sclk_q    <= 1'b1;
            active_q  <= 1'b0;
        end else begin
            div_q     <= div_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            sclk_q    <= sclk_d;
            active_q  <= active_d;
        end
    end

    // mosi is the shift register MSB, so it changes only when sclk falls.
    assign sclk = sclk_q;
    assign mosi = shreg_q[PIXEL_BITS-1];

endmodule

// File: rtl/oled_pixel_tx.sv
// Scan-side pixel driver for the 96x64 RGB565 OLED. The block sweeps (x, y)
// out to a combinational colour source, fetches each colour and sends it
// MSB-first over SPI through spi_shift16. The block sends pixel data only.
// Optional build macro OLED_PIXEL_TX_CONTINUOUS_EN: frames repeat forever
// after the first frame_req, with DONE going straight back to FETCH.
module oled_pixel_tx
    import oled_pkg::*;
#(
    parameter int CLK_DIV  = 2,
    parameter int SCREEN_W = oled_pkg::SCREEN_W,
    parameter int SCREEN_H = oled_pkg::SCREEN_H
) (
    input  logic            clk,
    input  logic            reset,
    oled_pixel_tx_if.slave  bus
);

    localparam logic [X_BITS-1:0] X_LAST = X_BITS'(SCREEN_W - 1);
    localparam logic [Y_BITS-1:0] Y_LAST = Y_BITS'(SCREEN_H - 1);

    state_e            state_q, state_d;
    logic [X_BITS-1:0] x_q, x_d;
    logic [Y_BITS-1:0] y_q, y_d;
    logic              busy_q, busy_d;
    logic              frame_done_q, frame_done_d;
    logic              cs_n_q, cs_n_d;
    logic              load;
    logic              bit_done_last;
    logic              last_pixel;

    spi_shift16 #(
        .CLK_DIV (CLK_DIV)
    ) u_spi (
        .clk           (clk),
        .reset         (reset),
        .load          (load),
        .data          (bus.pixel_data),
        .bit_done_last (bit_done_last),
        .sclk          (bus.sclk),
        .mosi          (bus.mosi)
    );

    // Scan FSM and coordinate counters. Flags are decoded from the next state so they are registered.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        load    = 1'b0;

        last_pixel = (x_q == X_LAST) && (y_q == Y_LAST);

        case (state_q)
            IDLE: begin
                if (bus.frame_req) begin
                    x_d     = '0;
                    y_d     = '0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                // The colour for (x, y) is valid now. Capture it at this edge.
                load    = 1'b1;
                state_d = SHIFT;
            end
            SHIFT: begin
                if (bit_done_last) begin
                    if (last_pixel) begin
                        x_d     = '0;
                        y_d     = '0;
                        state_d = DONE;
                    end else if (x_q == X_LAST) begin
                        x_d     = '0;
                        y_d     = y_q + Y_BITS'(1);
                        state_d = FETCH;
                    end else begin
                        x_d     = x_q + X_BITS'(1);
                        state_d = FETCH;
                    end
                end
            end
            DONE: begin
`ifdef OLED_PIXEL_TX_CONTINUOUS_EN
                x_d     = '0;
                y_d     = '0;
                state_d = FETCH;
`else
                state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase

        busy_d       = (state_d != IDLE);
        frame_done_d = (state_d == DONE);
        cs_n_d       = (state_d == IDLE) || (state_d == DONE);
    end

    // State, coordinates and status flags. Reset aborts a frame at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            x_q          <= '0;
            y_q          <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            cs_n_q       <= 1'b1;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            cs_n_q       <= cs_n_d;
        end
    end

    assign bus.x          = x_q;
    assign bus.y          = y_q;
    assign bus.busy       = busy_q;
    assign bus.frame_done = frame_done_q;
    assign bus.cs_n       = cs_n_q;
    assign bus.dc         = 1'b1;

endmodule

// File: tb/tb_oled_pixel_tx.sv
// Self-checking bench for oled_pixel_tx on a reduced 12x5 screen with
// CLK_DIV=1. Expected pin values come from an arithmetic timeline model:
// cycle i after the frame_req sampling edge maps to pixel index and bit
// position. Expected colours are derived from the pixel index directly.
module tb_oled_pixel_tx;

    localparam int CD    = 1;
    localparam int W     = 12;
    localparam int H     = 5;
    localparam int NPIX  = W * H;
    localparam int PIX   = 1 + 32 * CD;
    localparam int FRAME = NPIX * PIX;
    localparam int P     = FRAME + 1;

    localparam int MODE_FIXED  = 0;
    localparam int MODE_RANDOM = 1;
    localparam int MODE_EXPR   = 2;

    logic        clk = 1'b0;
    logic        reset;
    int          errors = 0;
    int          checks = 0;
    int          mode   = MODE_FIXED;
    logic [15:0] tbl [NPIX];
    int          src_idx;

    oled_pixel_tx_if bus ();

    oled_pixel_tx #(
        .CLK_DIV  (CD),
        .SCREEN_W (W),
        .SCREEN_H (H)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Combinational colour source, as a renderer would be.
    always @* begin
        src_idx = int'(bus.y) * W + int'(bus.x);
        if (src_idx >= NPIX) src_idx = 0;
        case (mode)
            MODE_FIXED:  bus.pixel_data = 16'hF80D;
            MODE_RANDOM: bus.pixel_data = tbl[src_idx];
            default:     bus.pixel_data = {bus.x[4:0], bus.y, bus.x[4:0]};
        endcase
    end

    // Colour the source should produce for pixel number k of the scan.
    function automatic logic [15:0] exp_word(input int k);
        logic [6:0] xx;
        logic [5:0] yy;
        xx = 7'(k % W);
        yy = 6'(k / W);
        case (mode)
            MODE_FIXED:  return 16'hF80D;
            MODE_RANDOM: return tbl[k];
            default:     return {xx[4:0], yy, xx[4:0]};
        endcase
    endfunction

    // Timeline model: outputs in cycle i, where cycle 0 starts at the edge that sampled frame_req.
    function automatic void model(input int i,
                                  output logic [6:0] ex, output logic [5:0] ey,
                                  output logic ecs_n, output logic esclk,
                                  output logic ebusy, output logic edone,
                                  output int ebit, output int ek, output logic eword_end);
        int j, o, p;
        ex = '0; ey = '0; ecs_n = 1'b1; esclk = 1'b1; ebusy = 1'b0; edone = 1'b0;
        ebit = -1; ek = -1; eword_end = 1'b0;
`ifdef OLED_PIXEL_TX_CONTINUOUS_EN
        j = i % P;
`else
        j = i;
`endif
        if (j < FRAME) begin
            ek    = j / PIX;
            o     = j % PIX;
            ex    = 7'(ek % W);
            ey    = 6'(ek / W);
            ecs_n = 1'b0;
            ebusy = 1'b1;
            if (o > 0) begin
                p         = o - 1;
                ebit      = 15 - p / (2 * CD);
                esclk     = ((p % (2 * CD)) >= CD);
                eword_end = (o == PIX - 1);
            end
        end else if (j == FRAME) begin
            ebusy = 1'b1;
            edone = 1'b1;
        end
    endfunction

    task automatic do_reset();
        reset         = 1'b1;
        bus.frame_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Request a frame and check every pin in every cycle against the model.
    task automatic run_frames(input int nframes, input int inj_cycle, input string tag);
        logic [6:0]  ex;
        logic [5:0]  ey;
        logic        ecs_n, esclk, ebusy, edone, eword_end;
        int          ebit, ek;
        logic [15:0] ew;
        logic [15:0] recon = '0;
        int          last;
        int          done_seen = 0;
        int          done_exp  = 0;
`ifdef OLED_PIXEL_TX_CONTINUOUS_EN
        last = nframes * P + 2;
`else
        last = FRAME + 4;
        if (nframes < 1) last = 0;
`endif
        @(negedge clk);
        bus.frame_req = 1'b1;
        @(posedge clk);
        for (int i = 0; i <= last; i++) begin
            @(negedge clk);
            bus.frame_req = (i == inj_cycle);
            model(i, ex, ey, ecs_n, esclk, ebusy, edone, ebit, ek, eword_end);
            if (bus.frame_done === 1'b1) done_seen++;
            if (edone) done_exp++;
            checks++;
            if ({bus.x, bus.y, bus.cs_n, bus.sclk, bus.busy, bus.frame_done, bus.dc} !==
                {ex, ey, ecs_n, esclk, ebusy, edone, 1'b1}) begin
                errors++;
                $display("FAIL %s pins cycle %0d: got x=%0d y=%0d cs_n=%b sclk=%b busy=%b done=%b dc=%b, want x=%0d y=%0d cs_n=%b sclk=%b busy=%b done=%b dc=1",
                         tag, i, bus.x, bus.y, bus.cs_n, bus.sclk, bus.busy, bus.frame_done, bus.dc,
                         ex, ey, ecs_n, esclk, ebusy, edone);
            end
            if (ebit >= 0) begin
                ew = exp_word(ek);
                checks++;
                if (bus.mosi !== ew[ebit]) begin
                    errors++;
                    $display("FAIL %s mosi cycle %0d pixel %0d bit %0d: got %b want %b",
                             tag, i, ek, ebit, bus.mosi, ew[ebit]);
                end
                if (esclk) recon[ebit] = bus.mosi;
                if (eword_end) begin
                    checks++;
                    if (recon !== ew) begin
                        errors++;
                        $display("FAIL %s word pixel %0d: got %h want %h", tag, ek, recon, ew);
                    end
                end
            end
        end
        checks++;
        if (done_seen != done_exp) begin
            errors++;
            $display("FAIL %s frame_done count: got %0d want %0d", tag, done_seen, done_exp);
        end
    endtask

    task automatic test_reset();
        int target;
        int stray_done = 0;
        int stray_busy = 0;
        reset         = 1'b1;
        bus.frame_req = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.x, bus.y, bus.busy, bus.frame_done, bus.cs_n, bus.sclk, bus.mosi, bus.dc} !==
            {7'd0, 6'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset values: got x=%0d y=%0d busy=%b done=%b cs_n=%b sclk=%b mosi=%b dc=%b, want 0 0 0 0 1 1 0 1",
                     bus.x, bus.y, bus.busy, bus.frame_done, bus.cs_n, bus.sclk, bus.mosi, bus.dc);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.busy, bus.cs_n, bus.sclk} !== 3'b011) begin
            errors++;
            $display("FAIL idle after reset: got busy=%b cs_n=%b sclk=%b want 0 1 1", bus.busy, bus.cs_n, bus.sclk);
        end

        // Abort in the middle of pixel (10,3).
        mode   = MODE_RANDOM;
        target = (3 * W + 10) * PIX + 5;
        bus.frame_req = 1'b1;
        @(posedge clk);
        for (int i = 0; i <= target; i++) begin
            @(negedge clk);
            bus.frame_req = 1'b0;
        end
        checks++;
        if ({bus.x, bus.y, bus.cs_n, bus.busy} !== {7'd10, 6'd3, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL pre-abort position: got x=%0d y=%0d cs_n=%b busy=%b want 10 3 0 1", bus.x, bus.y, bus.cs_n, bus.busy);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({bus.x, bus.y, bus.busy, bus.frame_done, bus.cs_n, bus.sclk, bus.mosi} !==
            {7'd0, 6'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL async abort: got x=%0d y=%0d busy=%b done=%b cs_n=%b sclk=%b mosi=%b, want 0 0 0 0 1 1 0",
                     bus.x, bus.y, bus.busy, bus.frame_done, bus.cs_n, bus.sclk, bus.mosi);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < P + 8; i++) begin
            @(negedge clk);
            if (bus.frame_done !== 1'b0) stray_done++;
            if (bus.busy !== 1'b0 || bus.cs_n !== 1'b1) stray_busy++;
        end
        checks++;
        if (stray_done != 0 || stray_busy != 0) begin
            errors++;
            $display("FAIL after abort: got %0d frame_done cycles and %0d active cycles, want 0 and 0", stray_done, stray_busy);
        end
    endtask

    task automatic test_bit_order();
        do_reset();
        mode = MODE_FIXED;
        run_frames(1, -1, "bit_order");
    endtask

    task automatic test_random_data();
        do_reset();
        for (int k = 0; k < NPIX; k++) tbl[k] = 16'($urandom);
        tbl[0]        = 16'hFFFF;
        tbl[NPIX - 1] = 16'h0001;
        mode = MODE_RANDOM;
        run_frames(1, -1, "random");
    endtask

    task automatic test_expr_data();
        do_reset();
        mode = MODE_EXPR;
        run_frames(1, -1, "expr");
    endtask

    task automatic test_ignore();
        do_reset();
        for (int k = 0; k < NPIX; k++) tbl[k] = 16'($urandom);
        mode = MODE_RANDOM;
        // Request in mid-SHIFT of pixel (5,3), then in the DONE cycle.
        run_frames(1, (3 * W + 5) * PIX + 10, "ignore_shift");
        do_reset();
        run_frames(1, FRAME, "ignore_done");
    endtask

`ifndef OLED_PIXEL_TX_CONTINUOUS_EN
    task automatic test_back_to_back();
        do_reset();
        for (int k = 0; k < NPIX; k++) tbl[k] = 16'($urandom);
        mode = MODE_RANDOM;
        run_frames(1, -1, "b2b_first");
        mode = MODE_EXPR;
        run_frames(1, -1, "b2b_second");
    endtask
`else
    task automatic test_continuous();
        do_reset();
        mode = MODE_EXPR;
        run_frames(2, -1, "continuous");
    endtask
`endif

    initial begin
        reset         = 1'b1;
        bus.frame_req = 1'b0;
        for (int k = 0; k < NPIX; k++) tbl[k] = 16'($urandom);
        test_reset();
        test_bit_order();
        test_random_data();
        test_expr_data();
        test_ignore();
`ifndef OLED_PIXEL_TX_CONTINUOUS_EN
        test_back_to_back();
`else
        test_continuous();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
